// File: rtl/pb_debounce_pkg.sv
// rtl/pb_debounce_pkg.sv - shared types and sizing helpers for the pushbutton debouncer
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    HELD       = 2'd2,
    REL_PEND   = 2'd3
  } pb_state_t;

  localparam int PB_COUNT_W = 8;

  // Stability counter width; never narrower than one bit.
  function automatic int pb_cnt_w(input int stable_cycles);
    int w;
    w = $clog2(stable_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pb_sync.sv
// rtl/pb_sync.sv - two-flop synchroniser for asynchronous board inputs
module pb_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - synchronise, debounce and count presses of one pushbutton
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 50000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pb_raw,
  input  logic                  count_clr,
  output logic                  pb_level,
  output logic                  press_pulse,
  output logic                  release_pulse,
  output logic [PB_COUNT_W-1:0] press_count
);

  localparam int               CNT_W    = pb_cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic            raw_sync;
  logic            s;
  logic [CNT_W-1:0] cnt;
  pb_state_t       state;
  logic            press_accept;

  pb_sync #(
    .RESET_VAL (RAW_IDLE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pb_raw),
    .q       (raw_sync)
  );

  // s is 1 when the button is pressed regardless of board polarity.
  assign s = raw_sync ^ RAW_IDLE;

  assign press_accept = (state == PRESS_PEND) && s && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      pb_level      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_PEND;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        PRESS_PEND: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= HELD;
            cnt         <= '0;
            pb_level    <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state <= REL_PEND;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        REL_PEND: begin
          if (s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= RELEASED;
            cnt           <= '0;
            pb_level      <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A clear in the same cycle as an accepted press takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_count <= '0;
    end else if (count_clr) begin
      press_count <= '0;
    end else if (press_accept) begin
      press_count <= press_count + PB_COUNT_W'(1);
    end
  end

endmodule

// File: doc/pb_debounce.md
# pb_debounce

Pushbutton conditioning stage that sits directly upstream of the Nios PIO pushbutton input port. It synchronises a raw, bouncing, asynchronous button signal into `clk`, then debounces it with a stability counter and a four-state FSM. It produces a clean active-high level that drives the PIO `in_port`, one-cycle press and release pulses, and a wrapping press counter for diagnostics.

## Interface
- `STABLE_CYCLES`, default 50000: consecutive stable synchronised samples required to accept a change (1 ms at 50 MHz). Legal range is 2 to 2^20.
- `ACTIVE_LOW`, default 1: when 1, raw level 0 means pressed (board buttons); when 0, raw level 1 means pressed.
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, asynchronous, active-low; clock `clk`.
- `pb_raw`  in  1: raw button pin, asynchronous to `clk`.
- `count_clr`  in  1: synchronous clear of `press_count`.
- `pb_level`  out  1: debounced level, 1 = pressed. Feeds the PIO `in_port`.
- `press_pulse`  out  1: single-cycle strobe on an accepted press.
- `release_pulse`  out  1: single-cycle strobe on an accepted release.
- `press_count`  out  8: number of accepted presses, modulo 256.

## Operation
- **Synchroniser:** 2-flop chain on `pb_raw`. On reset, both flops load the released raw level (1 if `ACTIVE_LOW`, else 0).
- **Normalisation:** the stage-2 output is normalised so that `s` = 1 means pressed.
- **Counter:** `cnt` is `$clog2(STABLE_CYCLES)` bits wide and is reset to 0.
- **FSM states:** RELEASED, PRESS_PEND, HELD, REL_PEND. Reset state is RELEASED.
- **RELEASED:**
  - `s`=1 → go to PRESS_PEND, `cnt`<=1.
  - Otherwise stay, `cnt`<=0.
- **PRESS_PEND:**
  - `s`=0 → go to RELEASED, `cnt`<=0 (bounce rejected, no pulse).
  - Else if `cnt`==STABLE_CYCLES-1 → go to HELD, `cnt`<=0, `pb_level`<=1, `press_pulse`<=1, `press_count` increments.
  - Else `cnt`++.
- **HELD:** mirror of RELEASED, using `s`=0 to go to REL_PEND with `cnt`<=1.
- **REL_PEND:**
  - `s`=1 → go to HELD, `cnt`<=0.
  - Else if `cnt`==STABLE_CYCLES-1 → go to RELEASED, `pb_level`<=0, `release_pulse`<=1.
  - Else `cnt`++.
- **Registered outputs:** `pb_level` is a registered output, set and cleared only on the transitions above. It is never decoded combinationally from the state.
- **Pulses:** both pulse outputs are registered, high for exactly one cycle, and default to 0 on every other cycle. They are never high simultaneously.
- **press_count:**
  - 8-bit, wraps from 255 to 0 with no saturation and no flag.
  - `count_clr`=1 loads 0.
  - If `count_clr` and an accepted press occur in the same cycle, the clear wins: the result is 0, not 1. `press_pulse` still fires.

## Timing
- **Reset values:** `pb_level`=0, `press_pulse`=0, `release_pulse`=0, `press_count`=0, FSM=RELEASED, `cnt`=0.
- **Reset mid-operation:** reset asserted in any state returns all outputs to their reset values immediately (asynchronous). No pulse is emitted on reset entry or exit.
- **Deassertion:** `reset_n` deassertion is synchronised externally. The block assumes it is clean relative to `clk`.
- **Latency:**
  - A clean raw edge reaches `s` after 2 clock edges.
  - `pb_level` changes on the edge after the STABLE_CYCLES-th consecutive agreeing `s` sample.
  - Total: STABLE_CYCLES+2 edges from raw change to `pb_level` change. The pulse occurs in the same cycle that `pb_level` changes.
- **Bounce handling:**
  - Any disagreeing sample during a PEND state restarts the qualification from zero.
  - Glitches shorter than STABLE_CYCLES samples never reach `pb_level`.
- **Minimum spacing:** each accepted transition requires its own STABLE_CYCLES window, so the minimum spacing between `press_pulse` and the next `release_pulse` is STABLE_CYCLES cycles.

## Structure
- **Package `pb_debounce_pkg`:**
  - State enum `pb_state_t` (RELEASED, PRESS_PEND, HELD, REL_PEND), 2-bit encoded.
  - Localparam `PB_CNT_W` computation helper.
  - Constant `PB_COUNT_W` = 8.
- **Sub-module `pb_sync`:** 2-flop synchroniser with parameter `RESET_VAL`. It is reused for the other board buttons and switches.
- **Top level:** FSM, counter and output registers in `pb_debounce`. Intended to be instantiated once per button ahead of each PIO input.

## Test plan
All scenarios use STABLE_CYCLES=4 and ACTIVE_LOW=1.
1. **Reset:** hold `pb_raw`=1 and release reset → all outputs 0 for 20 cycles, no pulses.
2. **Clean press:** drive `pb_raw` 1→0 and hold → `pb_level` rises exactly 6 edges later; `press_pulse` is high for 1 cycle in that cycle; `press_count`=1.
3. **Bounce on press:** drive `pb_raw` low 3 cycles, high 1, low 3, high 1, then low steady → `pb_level` rises 6 edges after the final falling edge; exactly one `press_pulse`.
4. **Release:** from HELD, drive `pb_raw` 0→1 → `pb_level` falls 6 edges later; one `release_pulse`; `press_count` unchanged.
5. **Wrap and clear:**
   - Perform 256 press/release cycles → `press_count` reads 0.
   - Assert `count_clr` in the same cycle as an accepted press → `press_count`=0 and `press_pulse`=1.
6. **Reset mid-pend:** assert `reset_n`=0 during PRESS_PEND with `cnt`=2 → outputs 0 immediately, no pulse. After release with `pb_raw`=0, a full 6-edge qualification is required.
